// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, defaults and helpers for the UART TX path
package uart_pkg;

  // Default byte width carried by requesters and the serializer
  localparam int DEFAULT_DATA_WIDTH = 8;

  // One-hot scheduler state encoding
  localparam logic [3:0] SCHED_IDLE   = 4'b0001;
  localparam logic [3:0] SCHED_LAUNCH = 4'b0010;
  localparam logic [3:0] SCHED_WAIT   = 4'b0100;
  localparam logic [3:0] SCHED_GAP    = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE   = SCHED_IDLE,
    ST_LAUNCH = SCHED_LAUNCH,
    ST_WAIT   = SCHED_WAIT,
    ST_GAP    = SCHED_GAP
  } sched_state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Larger of two sizing constants
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just above the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   pointer,
  output logic [SEL_W-1:0]   sel,
  output logic               valid
);

  logic [SEL_W-1:0] cand;

  // Walk pointer+1 .. pointer+NUM_REQ (mod NUM_REQ); the first set request wins
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SEL_W'((int'(pointer) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        sel   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one UART transmitter with gap and timeout
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IDW           = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [IDW-1:0]                active_id,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          sched_busy,
  output logic                          timeout_err
);

  // One counter serves both the WAIT_DONE timeout and the GAP countdown
  localparam int CNT_W = (clog2(max2(GAP_CYCLES, TIMEOUT_CYCLES) + 1) > 0) ?
                          clog2(max2(GAP_CYCLES, TIMEOUT_CYCLES) + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  sched_state_t          state;
  logic [IDW-1:0]        ptr;
  logic [CNT_W-1:0]      cnt;
  logic [IDW-1:0]        arb_sel;
  logic                  arb_valid;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (IDW)
  ) u_arb (
    .req     (req),
    .pointer (ptr),
    .sel     (arb_sel),
    .valid   (arb_valid)
  );

  assign sel_data = req_data[arb_sel*DATA_WIDTH +: DATA_WIDTH];

  // Scheduler FSM: grant, launch, wait for completion or timeout, then hold off for the gap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ptr         <= IDW'(NUM_REQ - 1);
      cnt         <= '0;
      grant       <= '0;
      active_id   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      sched_busy  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      grant       <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A busy transmitter blocks arbitration entirely
          if (arb_valid && !tx_busy) begin
            grant      <= NUM_REQ'(1) << arb_sel;
            tx_data    <= sel_data;
            active_id  <= arb_sel;
            ptr        <= arb_sel;
            sched_busy <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tx_start <= 1'b1;
          cnt      <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // tx_done has priority over a coinciding timeout
          if (tx_done || (cnt == TIMEOUT_LAST)) begin
            timeout_err <= !tx_done;
            if (GAP_CYCLES == 0) begin
              cnt        <= '0;
              sched_busy <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              cnt   <= GAP_LOAD;
              state <= ST_GAP;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt <= CNT_ONE) begin
            cnt        <= '0;
            sched_busy <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          cnt        <= '0;
          sched_busy <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmitter between NUM_REQ byte requesters using round-robin arbitration. For each accepted request it latches one byte, issues a single-cycle start pulse to the transmitter, and waits for frame completion. It then enforces a minimum inter-frame gap before arbitrating again. It sits between the key/pulse controllers and the UART TX serializer, and it flags transmitters that never complete a frame.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width per request
GAP_CYCLES, 16, idle clocks enforced after each frame completes (0 allowed)
TIMEOUT_CYCLES, 4096, clocks allowed in WAIT_DONE before a timeout is declared (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester, held until granted
req_data  in  NUM_REQ*DATA_WIDTH  byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
grant  out  NUM_REQ  one-hot, one-cycle acknowledge to the winning requester
active_id  out  clog2(NUM_REQ)  index of the last granted requester
tx_start  out  1  one-cycle start pulse to the transmitter
tx_data  out  DATA_WIDTH  latched byte, stable from tx_start until the next grant
tx_busy  in  1  transmitter busy level
tx_done  in  1  one-cycle frame-complete pulse from the transmitter
sched_busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse when TIMEOUT_CYCLES expires

Behaviour:
- Reset (async assert, sync release) drives these values:
  - Outputs: grant=0, active_id=0, tx_start=0, tx_data=0, sched_busy=0, timeout_err=0.
  - Internal: state=IDLE, RR pointer=NUM_REQ-1 (requester 0 has first priority), counters=0.
- All outputs are registered.
- One-hot FSM with states IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - If req!=0 and tx_busy==0: select the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - At the next edge: grant[sel]=1, tx_data=req_data[sel], active_id=sel, pointer=sel, go to LAUNCH.
  - If tx_busy==1: no arbitration, stay in IDLE.
- LAUNCH:
  - tx_start=1 and grant=0 for exactly this one cycle.
  - Timeout counter cleared. Go to WAIT_DONE.
  - Latency: req sampled in cycle N -> grant in N+1 -> tx_start in N+2.
- WAIT_DONE:
  - Timeout counter increments each cycle.
  - On tx_done: go to GAP, or to IDLE if GAP_CYCLES==0. Load the gap counter with GAP_CYCLES.
  - If the counter reaches TIMEOUT_CYCLES-1 without tx_done: timeout_err pulses for one cycle and the FSM proceeds exactly as for tx_done.
  - If tx_done and the timeout coincide, tx_done wins and timeout_err stays 0.
  - tx_done outside WAIT_DONE is ignored.
- GAP: the counter decrements each cycle. At 1 -> IDLE, so exactly GAP_CYCLES cycles are spent in GAP.
- A requester must drop req in the cycle after grant. A req still high is treated as a new request and is served again after the gap.
- A req deasserted before grant is simply never served. There is no latching of unserved requests.
- Counters are sized clog2(max(GAP_CYCLES,TIMEOUT_CYCLES)+1) and never wrap.
- Reset asserted mid-frame aborts immediately to the reset values. No tx_start or grant is produced during or on release of reset.

Decomposition:
- Shared package uart_pkg holds:
  - the one-hot state localparams SCHED_IDLE/SCHED_LAUNCH/SCHED_WAIT/SCHED_GAP;
  - the default DATA_WIDTH;
  - a clog2 helper function.
- One sub-module, rr_arbiter: combinational round-robin pick, with inputs req and pointer and outputs sel plus valid. It is reusable by other shared resources.
- The pointer register and the FSM stay in uart_tx_scheduler.

Test Plan:
- Single request: req=4'b0100, req_data[2]=8'hA5, tx_done pulsed 10 cycles after tx_start -> grant=4'b0100 at N+1, tx_start with tx_data=8'hA5 at N+2, sched_busy low exactly 16 cycles after tx_done.
- Contention: req=4'b1111 held with tx_done returned each frame -> grant order 0,1,2,3,0; active_id follows; no requester is granted twice before all are served.
- Transmitter busy: tx_busy=1 with req=4'b0001 -> no grant; tx_busy drops -> grant the cycle after.
- Timeout: tx_done never pulsed, TIMEOUT_CYCLES=32 -> timeout_err a single pulse 32 cycles after tx_start, then GAP, then IDLE; same-cycle tx_done at the boundary -> no timeout_err.
- Reset mid-frame: reset_n low during WAIT_DONE -> all outputs 0 asynchronously; after release req=4'b1000,4'b0001 simultaneously -> requester 0 granted first (pointer reset).
- GAP_CYCLES=0 build: tx_done -> IDLE next cycle; back-to-back frames spaced exactly by tx_done + 2 cycles.
